// File: rtl/score_pkg.sv
// Shared constants for the dino-game score keeper:
// game-state encodings and active-low 7-segment glyphs.
package score_pkg;

  localparam logic [1:0] GAME_INIT  = 2'd0;
  localparam logic [1:0] GAME_START = 2'd1;
  localparam logic [1:0] GAME_END   = 2'd2;
  localparam logic [1:0] GAME_RESET = 2'd3;

  // Segment order {g,f,e,d,c,b,a}, low = lit
  localparam logic [6:0] ZERO  = 7'b1000000;
  localparam logic [6:0] ONE   = 7'b1111001;
  localparam logic [6:0] TWO   = 7'b0100100;
  localparam logic [6:0] THREE = 7'b0110000;
  localparam logic [6:0] FOUR  = 7'b0011001;
  localparam logic [6:0] FIVE  = 7'b0010010;
  localparam logic [6:0] SIX   = 7'b0000010;
  localparam logic [6:0] SEVEN = 7'b1111000;
  localparam logic [6:0] EIGHT = 7'b0000000;
  localparam logic [6:0] NINE  = 7'b0010000;
  localparam logic [6:0] NONE  = 7'b1111111;

endpackage

// File: rtl/seg7_decode.sv
// One BCD digit to active-low 7-segment pattern;
// non-BCD codes blank the digit.
module seg7_decode
  import score_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = NONE;
    case (bcd)
      4'd0: seg = ZERO;
      4'd1: seg = ONE;
      4'd2: seg = TWO;
      4'd3: seg = THREE;
      4'd4: seg = FOUR;
      4'd5: seg = FIVE;
      4'd6: seg = SIX;
      4'd7: seg = SEVEN;
      4'd8: seg = EIGHT;
      4'd9: seg = NINE;
      default: seg = NONE;
    endcase
  end

endmodule

// File: rtl/score_keeper.sv
// BCD score / high-score tracker with record blink
// and a multi-digit active-low 7-segment output.
module score_keeper
  import score_pkg::*;
#(
  parameter int DIGITS          = 4,
  parameter int TICKS_PER_POINT = 36,
  parameter int BLINK_HALF      = 8,
  parameter int LZ_BLANK        = 0
) (
  input  logic                  game_clk,
  input  logic                  rst,
  input  logic [1:0]            game_state,
  input  logic                  mode,
  output logic [4*DIGITS-1:0]   score_bcd,
  output logic [4*DIGITS-1:0]   high_bcd,
  output logic                  score_tick,
  output logic                  new_record,
  output logic [7*DIGITS-1:0]   display_all
);

  localparam int W  = 4 * DIGITS;
  localparam int TW = $clog2(TICKS_PER_POINT);
  localparam int BW = $clog2(2 * BLINK_HALF);

  localparam logic [TW-1:0] TMAX = TW'(TICKS_PER_POINT - 1);
  localparam logic [BW-1:0] BMAX = BW'(2 * BLINK_HALF - 1);
  localparam logic [BW-1:0] BHLF = BW'(BLINK_HALF);
  localparam logic [W-1:0]  NINES = {DIGITS{4'h9}};

  logic [TW-1:0] tick;
  logic [BW-1:0] blink;
  logic [W-1:0]  inc;
  logic          carry;
  logic          all_nines;

  // Ripple the +1 through every digit in a single cycle
  always_comb begin
    inc   = score_bcd;
    carry = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (score_bcd[4*i +: 4] == 4'd9) begin
          inc[4*i +: 4] = 4'd0;
        end else begin
          inc[4*i +: 4] = score_bcd[4*i +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
    end
  end

  assign all_nines = (score_bcd == NINES);

  always_ff @(posedge game_clk or posedge rst) begin
    if (rst) begin
      score_bcd  <= '0;
      high_bcd   <= '0;
      tick       <= '0;
      blink      <= '0;
      score_tick <= 1'b0;
      new_record <= 1'b0;
    end else begin
      score_tick <= 1'b0;
      case (game_state)
        GAME_START: begin
          blink <= '0;
          if (tick == TMAX) begin
            tick <= '0;
            if (!all_nines) begin
              score_bcd  <= inc;
              score_tick <= 1'b1;
            end
          end else begin
            tick <= tick + TW'(1);
          end
        end
        GAME_END: begin
          if (score_bcd > high_bcd) begin
            high_bcd   <= score_bcd;
            new_record <= 1'b1;
          end
          if (new_record)
            blink <= (blink == BMAX) ? '0 : blink + BW'(1);
          else
            blink <= '0;
        end
        default: begin
          score_bcd  <= '0;
          tick       <= '0;
          blink      <= '0;
          new_record <= 1'b0;
        end
      endcase
    end
  end

  logic [W-1:0]          src;
  logic [7*DIGITS-1:0]   raw;
  logic                  blank_all;
  logic                  keep;

  assign src       = mode ? high_bcd : score_bcd;
  assign blank_all = (blink >= BHLF);

  for (genvar g = 0; g < DIGITS; g++) begin : g_dec
    seg7_decode u_dec (
      .bcd (src[4*g +: 4]),
      .seg (raw[7*g +: 7])
    );
  end

  // Scan from the top digit down; once a nonzero digit is seen, show the rest
  always_comb begin
    display_all = raw;
    keep        = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      keep = keep || (src[4*i +: 4] != 4'd0) || (i == 0);
      if (blank_all || (LZ_BLANK != 0 && !keep))
        display_all[7*i +: 7] = NONE;
    end
  end

endmodule

// File: doc/score_keeper.md
# score_keeper

Parametrised score/high-score tracker for the dino game, driven by the game state machine on `game_clk`. It counts points in native BCD (no dividers), saturates at all-nines and latches a high score on game end. It flags and blinks a new record, and drives a DIGITS-wide active-low 7-segment bus selectable between current and high score. Sits between the game FSM and the seven-segment scanner.

## Interface
- `DIGITS`, 4, number of decimal digits (1–8).
- `TICKS_PER_POINT`, 36, `game_clk` cycles in GAME_START per point (≥2).
- `BLINK_HALF`, 8, `game_clk` cycles per blink half-period (≥1).
- `LZ_BLANK`, 0, 1 = blank leading zeros (digit 0 always shown).
- `game_clk`  in  1  game clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `game_state`  in  2  0 INIT, 1 START, 2 END, 3 RESET.
- `mode`  in  1  0 = show score, 1 = show high score.
- `score_bcd`  out  4*DIGITS  current score, BCD, digit 0 at [3:0].
- `high_bcd`  out  4*DIGITS  high score, BCD.
- `score_tick`  out  1  one-cycle pulse on each score increment.
- `new_record`  out  1  high score was beaten this game.
- `display_all`  out  7*DIGITS  active-low segments {g..a}, digit 0 at [6:0].

## Operation
- Reset: score, high, tick counter, blink counter = 0; `score_tick`=0; `new_record`=0; `display_all` shows all `0` (or blanks above digit 0 when LZ_BLANK=1).
- INIT / RESET: score=0, tick counter=0, `new_record`=0, blink counter=0. High score is held.
- START: tick counter counts 0..TICKS_PER_POINT-1. At the edge where it wraps, the score increments by 1 and `score_tick`=1 for that cycle.
- Increment is BCD ripple: digit 9→0 with carry, all digits updated in one cycle.
- Saturation: at all-nines the score holds, `score_tick` stays 0, and the tick counter keeps wrapping.
- END: score and tick counter hold. Each cycle, if score > high (unsigned compare of the BCD words), high ← score and `new_record` ← 1. Otherwise high holds.
- `new_record` stays 1 through END and START. It clears only in INIT/RESET or on `rst`.
- Blink: while `new_record`=1 and state=END, the blink counter counts 0..2*BLINK_HALF-1 and wraps. Count ≥ BLINK_HALF blanks every digit (7'b1111111). Otherwise the blink counter is 0 and the display is not blanked.
- Display source: `mode` selects score or high. The source is decoded per digit: 0 1000000, 1 1111001, 2 0100100, 3 0110000, 4 0011001, 5 0010010, 6 0000010, 7 1111000, 8 0000000, 9 0010000.
- Non-BCD nibble decodes to blank (1111111).
- LZ_BLANK=1: digits above the most-significant nonzero digit are blanked.

## Timing
- All state is registered on posedge `game_clk`, async clear on `rst`.
- `score_bcd`, `high_bcd`, `score_tick`, `new_record` are registered outputs.
- `display_all` is combinational from registers plus `mode`. `mode` changes are visible the same cycle.
- First point arrives TICKS_PER_POINT edges after entering START with the tick counter at 0.
- High update lands 1 edge after entering END. `new_record` asserts on the same edge.
- START→END on the wrap edge: no increment (state is sampled at the edge).
- `rst` mid-count or mid-blink: all registers clear immediately, including high.

## Structure
- Package `score_pkg`:
  - game-state constants GAME_INIT/START/END/RESET;
  - segment patterns ZERO..NINE, NONE.
- Sub-module `seg7_decode`: 4-bit BCD → 7-bit active-low, instantiated via generate per digit.
- Core: BCD increment chain, tick counter, high-score compare, blink counter, LZ mask.

## Test plan
- DIGITS=4, TPP=4. `rst`, then START for 40 cycles → `score_bcd`=16'h0010 and 10 `score_tick` pulses; `display_all` digit1=1111001, digit0=1000000.
- Preload to 0x0099 via START, one more point → 0x0100, with the carry rippling in one cycle.
- DIGITS=2, TPP=2, run 300 cycles → score saturates at 0x99 and `score_tick` stops after the 99th pulse.
- Score 0x0025, high 0 → END: next edge high=0x0025 and `new_record`=1. BLINK_HALF=2 gives the display pattern on,on,off,off repeating. RESET clears score and `new_record`, high stays 0x0025, `mode`=1 shows 0025.
- Later game ends at 0x0012 < high → high stays 0x0025, `new_record`=0, no blink.
- LZ_BLANK=1, score 0x0007 → digits 3..1 = 1111111, digit0 = 1111000. Assert `rst` mid-START → all outputs return to reset values that cycle.
